z80_fetch_sequencer: RTL and testbench

Parametrised successor to the single-byte opcode-fetch decoder front end. Runs complete Z80 instruction fetches, including opcode-fetch (OCF) machine cycles and prefix chains (CB, ED, DD, FD, DDCB, FDCB). For DDCB/FDCB it adds memory-read (MRD) cycles for the displacement and the final opcode. It then presents one assembled instruction to the execute stage and holds it until execute reports done. T-state counts are configurable, and WAIT_L stretches any M-cycle.

---
 rtl/z80_pkg.sv | 49 ++++
 rtl/z80_mcycle_timer.sv | 56 +++++
 rtl/z80_fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_z80_fetch_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_pkg.sv
// Shared types and constants for the Z80 instruction fetch sequencer.
// Covers prefix groups, fetch FSM states, prefix byte values and the prefix-chain update rule.
package z80_pkg;

    typedef enum logic [2:0] {
        PFX_NONE = 3'd0,
        PFX_CB   = 3'd1,
        PFX_ED   = 3'd2,
        PFX_DD   = 3'd3,
        PFX_FD   = 3'd4,
        PFX_DDCB = 3'd5,
        PFX_FDCB = 3'd6
    } prefix_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OCF  = 3'd1,
        S_DISP = 3'd2,
        S_XOP  = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_t;

    localparam logic [7:0] OP_CB = 8'hCB;
    localparam logic [7:0] OP_ED = 8'hED;
    localparam logic [7:0] OP_DD = 8'hDD;
    localparam logic [7:0] OP_FD = 8'hFD;

    // Width of the T-state counter; M-cycles up to 255 T-states long.
    localparam int T_W = 8;

    // Prefix group after byte b is fetched while group cur is pending.
    // Once CB or ED is pending, the next byte is the opcode and the group is frozen.
    function automatic prefix_t next_prefix(prefix_t cur, logic [7:0] b);
        prefix_t r;
        r = cur;
        if (cur != PFX_CB && cur != PFX_ED) begin
            case (b)
                OP_CB:   r = (cur == PFX_DD) ? PFX_DDCB :
                             (cur == PFX_FD) ? PFX_FDCB : PFX_CB;
                OP_ED:   r = PFX_ED;
                OP_DD:   r = PFX_DD;
                OP_FD:   r = PFX_FD;
                default: r = cur;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/z80_mcycle_timer.sv
// T-state counter for one Z80 M-cycle: T1 start, T2 stretched by WAIT_L, done at T-state N.
// With Z80_REFRESH_EN defined it also flags the T3..N tail used for refresh.
module z80_mcycle_timer
    import z80_pkg::*;
(
    input  logic           clk,
    input  logic           rst_L,
    input  logic           start_i,
    input  logic [T_W-1:0] length_i,
    input  logic           wait_l_i,
    output logic           start_o,
    output logic           bus_o,
    output logic           capture_o,
    output logic           done_o
`ifdef Z80_REFRESH_EN
    ,
    output logic           tail_o
`endif
);

    localparam logic [T_W-1:0] T1 = T_W'(1);
    localparam logic [T_W-1:0] T2 = T_W'(2);

    logic           active_q;
    logic [T_W-1:0] t_q;
    logic [T_W-1:0] len_q;

    // A start request wins over an ending cycle so back-to-back M-cycles have no gap.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            active_q <= 1'b0;
            t_q      <= '0;
            len_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            t_q      <= T1;
            len_q    <= length_i;
        end else if (active_q) begin
            if (t_q == len_q) begin
                active_q <= 1'b0;
                t_q      <= '0;
            end else if (t_q != T2 || wait_l_i) begin
                t_q <= t_q + T1;
            end
        end
    end

    assign start_o   = active_q && (t_q == T1);
    assign bus_o     = active_q && (t_q <= T2);
    assign capture_o = active_q && (t_q == T2) && wait_l_i;
    assign done_o    = active_q && (t_q == len_q);
`ifdef Z80_REFRESH_EN
    assign tail_o    = active_q && (t_q > T2);
`endif

endmodule

// File: rtl/z80_fetch_sequencer.sv
// Z80 instruction fetch front end: OCF/MRD sequencing through prefix chains, holding one instruction for execute.
// Optional macro Z80_REFRESH_EN adds the rfsh_bus strobe and the 7-bit r_reg refresh counter.
module z80_fetch_sequencer
    import z80_pkg::*;
#(
    parameter int OCF_T_STATES = 4,
    parameter int MRD_T_STATES = 3
) (
    input  logic         clk,
    input  logic         rst_L,
    input  logic         WAIT_L,
    input  logic         prev_done,
    input  logic [7:0]   opcode,
    output logic         OCF_start,
    output logic         OCF_done,
    output logic         OCF_bus,
    output logic         MRD_start,
    output logic         MRD_done,
    output logic         MRD_bus,
    output logic         inc_PC,
    output logic         instr_valid,
    output prefix_t      instr_prefix,
    output logic [7:0]   instr_opcode,
    output logic [7:0]   instr_disp,
    output fetch_state_t fsm_state_o
`ifdef Z80_REFRESH_EN
    ,
    output logic         rfsh_bus,
    output logic [6:0]   r_reg
`endif
);

    localparam logic [T_W-1:0] OCF_LEN = T_W'(OCF_T_STATES);
    localparam logic [T_W-1:0] MRD_LEN = T_W'(MRD_T_STATES);

    fetch_state_t   state_q, state_d;
    fetch_state_t   next_q, next_d;
    prefix_t        pfx_q, pfx_d;
    prefix_t        ipfx_q, ipfx_d;
    logic [7:0]     op_q, op_d;
    logic [7:0]     disp_q, disp_d;
    logic [7:0]     iop_q, iop_d;
    logic [7:0]     idisp_q, idisp_d;
    logic           tmr_start;
    logic [T_W-1:0] tmr_len;
    logic           t_start, t_bus, t_capture, t_done;
    logic           is_ocf, is_mrd;
    logic           grp_frozen, is_prefix_byte;

    assign is_ocf         = (state_q == S_OCF);
    assign is_mrd         = (state_q == S_DISP) || (state_q == S_XOP);
    assign grp_frozen     = (pfx_q == PFX_CB) || (pfx_q == PFX_ED);
    assign is_prefix_byte = (opcode == OP_CB) || (opcode == OP_ED) ||
                            (opcode == OP_DD) || (opcode == OP_FD);

    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        pfx_d     = pfx_q;
        op_d      = op_q;
        disp_d    = disp_q;
        ipfx_d    = ipfx_q;
        iop_d     = iop_q;
        idisp_d   = idisp_q;
        tmr_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d   = S_OCF;
                tmr_start = 1'b1;
                pfx_d     = PFX_NONE;
                disp_d    = '0;
            end
            S_OCF: begin
                // Decide the follow-up at capture; act on it when the cycle ends.
                if (t_capture) begin
                    pfx_d = next_prefix(pfx_q, opcode);
                    op_d  = opcode;
                    if (grp_frozen || !is_prefix_byte)
                        next_d = S_HOLD;
                    else if (opcode == OP_CB && (pfx_q == PFX_DD || pfx_q == PFX_FD))
                        next_d = S_DISP;
                    else
                        next_d = S_OCF;
                end
                if (t_done) begin
                    state_d   = next_q;
                    tmr_start = (next_q != S_HOLD);
                end
            end
            S_DISP: begin
                if (t_capture) disp_d = opcode;
                if (t_done) begin
                    state_d   = S_XOP;
                    tmr_start = 1'b1;
                end
            end
            S_XOP: begin
                if (t_capture) op_d = opcode;
                if (t_done) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (prev_done) begin
                    state_d   = S_OCF;
                    tmr_start = 1'b1;
                    pfx_d     = PFX_NONE;
                    disp_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The presented instruction is loaded once on entry to S_HOLD and then left alone.
        if (state_d == S_HOLD && state_q != S_HOLD) begin
            ipfx_d  = pfx_q;
            iop_d   = op_q;
            idisp_d = disp_q;
        end
    end

    assign tmr_len = (state_d == S_OCF) ? OCF_LEN : MRD_LEN;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= S_IDLE;
            next_q  <= S_IDLE;
            pfx_q   <= PFX_NONE;
            op_q    <= '0;
            disp_q  <= '0;
            ipfx_q  <= PFX_NONE;
            iop_q   <= '0;
            idisp_q <= '0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            pfx_q   <= pfx_d;
            op_q    <= op_d;
            disp_q  <= disp_d;
            ipfx_q  <= ipfx_d;
            iop_q   <= iop_d;
            idisp_q <= idisp_d;
        end
    end

`ifdef Z80_REFRESH_EN
    logic       t_tail;
    logic [6:0] r_q;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            r_q <= '0;
        else if (is_ocf && t_done)
            r_q <= r_q + 7'd1;
    end

    assign rfsh_bus = is_ocf && t_tail;
    assign r_reg    = r_q;
`endif

    z80_mcycle_timer u_timer (
        .clk       (clk),
        .rst_L     (rst_L),
        .start_i   (tmr_start),
        .length_i  (tmr_len),
        .wait_l_i  (WAIT_L),
        .start_o   (t_start),
        .bus_o     (t_bus),
        .capture_o (t_capture),
        .done_o    (t_done)
`ifdef Z80_REFRESH_EN
        ,
        .tail_o    (t_tail)
`endif
    );

    assign OCF_start    = is_ocf && t_start;
    assign OCF_done     = is_ocf && t_done;
    assign OCF_bus      = is_ocf && t_bus;
    assign MRD_start    = is_mrd && t_start;
    assign MRD_done     = is_mrd && t_done;
    assign MRD_bus      = is_mrd && t_bus;
    assign inc_PC       = (is_ocf || is_mrd) && t_capture;
    assign instr_valid  = (state_q == S_HOLD);
    assign instr_prefix = ipfx_q;
    assign instr_opcode = iop_q;
    assign instr_disp   = idisp_q;
    assign fsm_state_o  = state_q;

endmodule

// File: tb/tb_z80_fetch_sequencer.sv
// Bench for z80_fetch_sequencer: byte-queue memory, reactive WAIT_L/prev_done driver, scoreboard monitor.
// Build with Z80_REFRESH_EN to also check the refresh counter.
`timescale 1ns/1ps
module tb_z80_fetch_sequencer;
    import z80_pkg::*;

    localparam int OCF_N = 4;
    localparam int MRD_N = 3;

    // Handshake: instr_valid rises with a new instruction and holds it; a prev_done sample
    // while valid releases it, and the next OCF T1 must follow on the very next clock.

    logic         clk = 1'b0;
    logic         rst_L = 1'b0;
    logic         WAIT_L = 1'b1;
    logic         prev_done = 1'b0;
    logic [7:0]   opcode = 8'h00;
    logic         OCF_start, OCF_done, OCF_bus, MRD_start, MRD_done, MRD_bus, inc_PC, instr_valid;
    prefix_t      instr_prefix;
    logic [7:0]   instr_opcode, instr_disp;
    fetch_state_t fsm_state;
`ifdef Z80_REFRESH_EN
    logic         rfsh_bus;
    logic [6:0]   r_reg;
`endif

    z80_fetch_sequencer #(.OCF_T_STATES(OCF_N), .MRD_T_STATES(MRD_N)) dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .WAIT_L       (WAIT_L),
        .prev_done    (prev_done),
        .opcode       (opcode),
        .OCF_start    (OCF_start),
        .OCF_done     (OCF_done),
        .OCF_bus      (OCF_bus),
        .MRD_start    (MRD_start),
        .MRD_done     (MRD_done),
        .MRD_bus      (MRD_bus),
        .inc_PC       (inc_PC),
        .instr_valid  (instr_valid),
        .instr_prefix (instr_prefix),
        .instr_opcode (instr_opcode),
        .instr_disp   (instr_disp),
        .fsm_state_o  (fsm_state)
`ifdef Z80_REFRESH_EN
        ,
        .rfsh_bus     (rfsh_bus),
        .r_reg        (r_reg)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [2:0] pfx;
        logic [7:0] op;
        logic [7:0] disp;
        logic [7:0] nbytes;
        logic [7:0] nmrd;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_q[$];
    logic [7:0] stage_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    int   wait_mode = 0;   // 0 ready, 1 random, 2 wait_left lows in T2, 3 stuck low
    int   wait_left = 0;
    int   hold_len  = 0;
    int   hold_cnt  = 0;
    logic rand_hold = 1'b0;
    logic pop_pend  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input prefix_t p, input logic [7:0] op, input logic [7:0] d,
                                input int nb, input int nm);
        exp_t e;
        e.pfx    = p;
        e.op     = op;
        e.disp   = d;
        e.nbytes = 8'(nb);
        e.nmrd   = 8'(nm);
        return e;
    endfunction

    task automatic issue(input exp_t e);
        foreach (stage_q[i]) mem_q.push_back(stage_q[i]);
        stage_q.delete();
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] rand_plain();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255));
        while (b == OP_CB || b == OP_ED || b == OP_DD || b == OP_FD);
        return b;
    endfunction

    // Reference model: build an instruction from its shape, so the expectation comes from the shape.
    task automatic gen_random();
        int         kind;
        int         chain;
        logic [7:0] idx, op, d;
        prefix_t    p;
        kind  = $urandom_range(0, 5);
        chain = (kind >= 3) ? $urandom_range(1, 3) : 0;
        idx   = 8'h00;
        for (int i = 0; i < chain; i++) begin
            idx = ($urandom_range(0, 1) != 0) ? OP_DD : OP_FD;
            stage_q.push_back(idx);
        end
        p  = (chain == 0) ? PFX_NONE : ((idx == OP_DD) ? PFX_DD : PFX_FD);
        op = 8'($urandom_range(0, 255));
        d  = 8'($urandom_range(0, 255));
        case (kind)
            1: begin
                stage_q.push_back(OP_CB); stage_q.push_back(op);
                issue(mk(PFX_CB, op, 8'h00, 2, 0));
            end
            2, 5: begin
                stage_q.push_back(OP_ED); stage_q.push_back(op);
                issue(mk(PFX_ED, op, 8'h00, chain + 2, 0));
            end
            4: begin
                stage_q.push_back(OP_CB); stage_q.push_back(d); stage_q.push_back(op);
                issue(mk((idx == OP_DD) ? PFX_DDCB : PFX_FDCB, op, d, chain + 3, 2));
            end
            default: begin
                op = rand_plain();
                stage_q.push_back(op);
                issue(mk(p, op, 8'h00, chain + 1, 0));
            end
        endcase
    endtask

    // ---------------- driver: memory, WAIT_L, prev_done ----------------
    always @(negedge clk) begin
        if (pop_pend && mem_q.size() > 0) void'(mem_q.pop_front());
        pop_pend = 1'b0;
        opcode = (mem_q.size() > 0) ? mem_q[0] : 8'h00;
        case (wait_mode)
            1: WAIT_L = ($urandom_range(0, 2) != 0);
            2: begin
                if ((OCF_bus || MRD_bus) && !OCF_start && !MRD_start && wait_left > 0) begin
                    WAIT_L = 1'b0;
                    wait_left--;
                end else begin
                    WAIT_L = 1'b1;
                end
            end
            3: WAIT_L = 1'b0;
            default: WAIT_L = 1'b1;
        endcase
        if (instr_valid) begin
            if (hold_cnt == 0 && rand_hold) hold_len = $urandom_range(1, 4);
            prev_done = (hold_cnt >= 1) && (hold_cnt >= hold_len) && (exp_q.size() > 0);
            hold_cnt++;
        end else begin
            hold_cnt  = 0;
            prev_done = ($urandom_range(0, 3) == 0);
        end
        #1;
        if (inc_PC && rst_L) pop_pend = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    logic        in_instr = 1'b0;
    logic        valid_d1 = 1'b0;
    logic        rel_pend = 1'b0;
    int          t0 = 0, n_inc = 0, n_mrd = 0, n_wait = 0;
    logic [18:0] held = '0;
    exp_t        cur;

    always @(negedge clk) begin
        #2;
        if (!rst_L) begin
            in_instr = 1'b0;
            valid_d1 = 1'b0;
            rel_pend = 1'b0;
        end else begin
            if (rel_pend) begin
                check("release_valid_drop", 32'(instr_valid), 32'd0);
                check("release_next_t1", 32'(OCF_start), 32'd1);
            end
            rel_pend = instr_valid && prev_done;
            if (OCF_start && !in_instr) begin
                in_instr = 1'b1;
                t0 = cyc; n_inc = 0; n_mrd = 0; n_wait = 0;
            end
            if (in_instr) begin
                if (inc_PC) n_inc++;
                if (MRD_start) n_mrd++;
                if ((OCF_bus || MRD_bus) && !OCF_start && !MRD_start && !WAIT_L) n_wait++;
            end
            if (instr_valid && !valid_d1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_instr: got prefix %0d opcode %0h, expected none",
                             instr_prefix, instr_opcode);
                end else begin
                    cur = exp_q.pop_front();
                    check("instr_prefix", 32'(instr_prefix), 32'(cur.pfx));
                    check("instr_opcode", 32'(instr_opcode), 32'(cur.op));
                    check("instr_disp", 32'(instr_disp), 32'(cur.disp));
                    check("inc_pc_count", 32'(n_inc), 32'(cur.nbytes));
                    check("mrd_count", 32'(n_mrd), 32'(cur.nmrd));
                    check("latency", 32'(cyc - t0),
                          32'((int'(cur.nbytes) - int'(cur.nmrd)) * OCF_N + int'(cur.nmrd) * MRD_N + n_wait));
                end
                check("hold_entry_quiet", {27'd0, OCF_bus, MRD_bus, OCF_start, MRD_start, inc_PC}, 32'd0);
                in_instr = 1'b0;
                held = {instr_prefix, instr_opcode, instr_disp};
            end else if (instr_valid) begin
                check("hold_stable", 32'({instr_prefix, instr_opcode, instr_disp}), 32'(held));
                check("hold_quiet", {27'd0, OCF_bus, MRD_bus, OCF_start, MRD_start, inc_PC}, 32'd0);
            end
            valid_d1 = instr_valid;
        end
    end

    // ---------------- directed sequence + random phase ----------------
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic run_one(output int drop_cnt, output int lat, output int n_bus, output int n_pc);
        drop_cnt = 0; lat = 0; n_bus = 0; n_pc = 0;
        while (instr_valid && drop_cnt < 200) begin step(); drop_cnt++; end
        if (instr_valid) check("timeout_release", 32'(instr_valid), 32'd0);
        while (!instr_valid && lat < 200) begin
            if (OCF_bus) n_bus++;
            if (inc_PC) n_pc++;
            step();
            lat++;
        end
        if (!instr_valid) check("timeout_valid", 32'(instr_valid), 32'd1);
    endtask

    function automatic logic [31:0] all_outputs();
        return {5'd0, OCF_start, OCF_done, OCF_bus, MRD_start, MRD_done, MRD_bus, inc_PC,
                instr_valid, instr_prefix, instr_opcode, instr_disp};
    endfunction

    initial begin
        int drop_cnt, lat, n_bus, n_pc, guard;

        rst_L = 1'b0;
        repeat (3) step();
        check("reset_outputs", all_outputs(), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(S_IDLE));
`ifdef Z80_REFRESH_EN
        check("reset_r_reg", 32'(r_reg), 32'd0);
`endif

        // Unprefixed NOP, exact clock positions
        stage_q.push_back(8'h00);
        issue(mk(PFX_NONE, 8'h00, 8'h00, 1, 0));
        rst_L = 1'b1;
        step();
        check("t1_ocf_start", 32'({OCF_start, OCF_bus}), 32'h3);
        step();
        check("t2_inc_pc", 32'({inc_PC, OCF_bus}), 32'h3);
        step();
        check("t3_bus_low", 32'({OCF_bus, OCF_done}), 32'h0);
        step();
        check("t4_ocf_done", 32'(OCF_done), 32'd1);
        step();
        check("clk4_valid", 32'({instr_valid, instr_prefix, instr_opcode}), 32'({1'b1, PFX_NONE, 8'h00}));

        // Two wait states in T2
        wait_mode = 2; wait_left = 2;
        stage_q.push_back(8'h3E);
        issue(mk(PFX_NONE, 8'h3E, 8'h00, 1, 0));
        run_one(drop_cnt, lat, n_bus, n_pc);
        check("wait_bus_clocks", 32'(n_bus), 32'd4);
        check("wait_inc_pc", 32'(n_pc), 32'd1);
        check("wait_valid_clock", 32'(lat), 32'(OCF_N + 2));
        wait_mode = 0;

        // Index chain DD FD 7E
        stage_q.push_back(OP_DD); stage_q.push_back(OP_FD); stage_q.push_back(8'h7E);
        issue(mk(PFX_FD, 8'h7E, 8'h00, 3, 0));
        run_one(drop_cnt, lat, n_bus, n_pc);
        check("chain_inc_pc", 32'(n_pc), 32'd3);
        check("chain_valid_clock", 32'(lat), 32'(3 * OCF_N));

        // Long hold, then release
        hold_len = 10;
        stage_q.push_back(8'h47);
        issue(mk(PFX_NONE, 8'h47, 8'h00, 1, 0));
        run_one(drop_cnt, lat, n_bus, n_pc);
        check("hold_release_clock", 32'(drop_cnt), 32'd11);
        hold_len = 0;

        // Reset in the T2 wait of an MRD cycle
        stage_q.push_back(OP_DD); stage_q.push_back(OP_CB);
        stage_q.push_back(8'h05); stage_q.push_back(8'h06);
        issue(mk(PFX_DDCB, 8'h06, 8'h05, 4, 2));
        guard = 0;
        while (instr_valid && guard < 100) begin step(); guard++; end
        while (!MRD_start && guard < 100) begin step(); guard++; end
        check("reach_mrd", 32'(MRD_start), 32'd1);
        wait_mode = 3;
        step();
        check("mrd_wait_bus", 32'(MRD_bus), 32'd1);
        #1 rst_L = 1'b0;
        #1 check("abort_outputs", all_outputs(), 32'd0);
        exp_q.delete(); mem_q.delete(); stage_q.delete();
        pop_pend = 1'b0;
        wait_mode = 0;
        step();
        step();
`ifdef Z80_REFRESH_EN
        check("abort_r_reg", 32'(r_reg), 32'd0);
`endif

        // DDCB after reset: refetch at T1, valid at clock 14
        stage_q.push_back(OP_DD); stage_q.push_back(OP_CB);
        stage_q.push_back(8'h05); stage_q.push_back(8'h06);
        issue(mk(PFX_DDCB, 8'h06, 8'h05, 4, 2));
        rst_L = 1'b1;
        step();
        check("refetch_t1", 32'(OCF_start), 32'd1);
        lat = 0;
        while (!instr_valid && lat < 200) begin step(); lat++; end
        check("ddcb_valid_clock", 32'(lat), 32'(2 * OCF_N + 2 * MRD_N));
`ifdef Z80_REFRESH_EN
        check("ddcb_r_reg", 32'(r_reg), 32'd2);
`endif

        // Randomised instruction stream with random waits and holds
        wait_mode = 1;
        rand_hold = 1'b1;
        for (int i = 0; i < 40; i++) gen_random();
        guard = 0;
        while (!(exp_q.size() == 0 && instr_valid && !valid_d1 == 1'b0) && guard < 8000) begin
            step();
            guard++;
        end
        check("random_drain", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
        check("bytes_consumed", 32'(mem_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
